// File: rtl/ahb_pkg.sv
// Shared AHB encodings, the responder FSM state type and the lane-strobe helper
// used by the SRAM responder.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1
  } hresp_e;

  typedef enum logic [2:0] {
    S_READY = 3'd0,
    S_WAIT  = 3'd1,
    S_DONE  = 3'd2,
    S_ERR1  = 3'd3,
    S_ERR2  = 3'd4
  } state_e;

  // Little-endian lane strobe; unsupported sizes strobe nothing.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module ahb_sram_array #(
  parameter int MEM_WORDS = 4096,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          i_clk,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder: one registered address phase, optional wait states and
// two-cycle ERROR responses. Handshake: an address phase is taken on a rising
// edge where I_HREADY and O_HREADYOUT are both high; the data phase ends on the
// first later edge where O_HREADYOUT is high.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 4096,
  parameter int          WAIT_STATES = 0
) (
  input  logic        I_HCLK,
  input  logic        I_HRESET,
  input  logic        I_HSEL,
  input  logic [31:0] I_HADDR,
  input  logic [1:0]  I_HTRANS,
  input  logic        I_HWRITE,
  input  logic [2:0]  I_HSIZE,
  input  logic [2:0]  I_HBURST,
  input  logic [31:0] I_HWDATA,
  input  logic        I_HREADY,
  output logic [31:0] O_HRDATA,
  output logic        O_HREADYOUT,
  output logic [1:0]  O_HRESP,
  output logic [2:0]  O_DBG_STATE
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [32:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + 33'(4 * MEM_WORDS);
  localparam logic [3:0]  WAIT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_valid, r_write, r_err;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [2:0]    r_size;

  logic          w_ready, w_accept, w_err;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_we;
  logic [31:0]   w_rdata;
  logic          w_unused;

  // Burst type and the BUSY/IDLE distinction carry no meaning here.
  assign w_unused = ^{I_HBURST, I_HTRANS[0]};

  assign w_ready  = (r_state != S_WAIT) && (r_state != S_ERR1);
  assign w_accept = I_HSEL & I_HREADY & I_HTRANS[1] & w_ready;
  assign w_idx    = AW'((I_HADDR - ADDR_BASE) >> 2);
  assign w_err    = ({1'b0, I_HADDR} < {1'b0, ADDR_BASE})
                  | ({1'b0, I_HADDR} >= ADDR_LIMIT)
                  | (I_HSIZE > HSIZE_WORD)
                  | ((I_HSIZE == HSIZE_HALF) & I_HADDR[0])
                  | ((I_HSIZE == HSIZE_WORD) & (I_HADDR[1:0] != 2'b00));

  always_ff @(posedge I_HCLK) begin
    if (I_HRESET) begin
      r_state <= S_READY;
      r_cnt   <= 4'd0;
      r_valid <= 1'b0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_lane  <= 2'd0;
      r_size  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (I_HREADY & w_ready) begin
        r_valid <= w_accept;
        r_write <= I_HWRITE;
        r_err   <= w_accept & w_err;
        r_idx   <= w_idx;
        r_lane  <= I_HADDR[1:0];
        r_size  <= I_HSIZE;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_ERR1:  w_state_nxt = S_ERR2;
      default: ;
    endcase
    // READY, DONE and ERR2 all end a data phase and may start the next one.
    if (w_ready) begin
      if (w_accept & w_err) begin
        w_state_nxt = S_ERR1;
      end else if (w_accept && (WAIT_STATES > 0)) begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = WAIT_INIT;
      end else begin
        w_state_nxt = S_READY;
      end
    end
  end

  assign w_we = (r_valid & r_write & ~r_err & w_ready & ~I_HRESET) ? byte_en(r_size, r_lane) : 4'b0000;

  ahb_sram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
    .i_clk   (I_HCLK),
    .i_we    (w_we),
    .i_addr  (r_idx),
    .i_wdata (I_HWDATA),
    .o_rdata (w_rdata)
  );

  assign O_HRDATA    = (r_valid & ~r_write & ~r_err) ? w_rdata : 32'd0;
  assign O_HREADYOUT = w_ready;
  assign O_HRESP     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign O_DBG_STATE = r_state;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Three responders on one bus (bases 0x0/0x1000_0000/0x2000_0000 with 0/2/3 wait
// states); a pipelined driver pushes expected responses, a forked monitor checks them.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int MW = 256;
  localparam int W  = 39;  // {check_data, resp[1:0], waits[3:0], data[31:0]}
  localparam logic [W-1:0] E_ERR = {1'b1, 2'd1, 4'd1, 32'd0};

  // clock / reset
  logic clk = 1'b0;
  logic hreset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] haddr = 32'd0, hwdata = 32'd0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0, hburst = 3'd0;

  logic [2:0]  rdy_v;
  logic [31:0] rdata_v [3];
  logic [1:0]  resp_v [3];
  logic [2:0]  dbg_v [3];

  logic [1:0]  dsel = 2'd0;
  logic        dp = 1'b0;
  logic        track = 1'b1;
  logic        hready;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  for (genvar k = 0; k < 3; k++) begin : g_slv
    ahb_sram_slave #(
      .ADDR_BASE   (32'(k) << 28),
      .MEM_WORDS   (MW),
      .WAIT_STATES ((k == 0) ? 0 : ((k == 1) ? 2 : 3))
    ) u_dut (
      .I_HCLK      (clk),
      .I_HRESET    (hreset),
      .I_HSEL      (haddr[31:28] == 4'(k)),
      .I_HADDR     (haddr),
      .I_HTRANS    (htrans),
      .I_HWRITE    (hwrite),
      .I_HSIZE     (hsize),
      .I_HBURST    (hburst),
      .I_HWDATA    (hwdata),
      .I_HREADY    (hready),
      .O_HRDATA    (rdata_v[k]),
      .O_HREADYOUT (rdy_v[k]),
      .O_HRESP     (resp_v[k]),
      .O_DBG_STATE (dbg_v[k])
    );
  end

  // Data-phase multiplexer, as a decoder would build it.
  assign hready = rdy_v[dsel];
  assign hrdata = rdata_v[dsel];
  assign hresp  = resp_v[dsel];

  always @(posedge clk) begin
    if (hready) dsel <= haddr[29:28];
    if (hreset)      dp <= 1'b0;
    else if (hready) dp <= (htrans != HTRANS_IDLE) && track;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic c, input logic [1:0] r, input logic [3:0] w,
                                      input logic [31:0] d);
    return {c, r, w, d};
  endfunction

  task automatic monitor();
    logic [W-1:0] e;
    int waits;
    logic resp_bad;
    waits = 0;
    resp_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (hreset) begin
        waits = 0;
        resp_bad = 1'b0;
      end else if (dp) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_phase: data phase with no expected transfer (t=%0t)", $time);
        end else if (!hready) begin
          e = exp_q[0];
          waits++;
          if (hresp !== e[37:36]) resp_bad = 1'b1;
        end else begin
          e = exp_q.pop_front();
          check("hresp", 32'(hresp), 32'(e[37:36]));
          check("wait_cycles", 32'(waits), 32'(e[35:32]));
          if (waits != 0) check("hresp_during_wait", 32'(resp_bad), 32'd0);
          if (e[38]) check("hrdata", hrdata, e[31:0]);
          waits = 0;
          resp_bad = 1'b0;
        end
      end
    end
  endtask

  // driver tasks
  task automatic issue(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                       input logic [2:0] sz, input logic [31:0] wd, input logic [W-1:0] e);
    int n;
    htrans = tr;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    n = 0;
    @(negedge clk);
    while (!hready && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("addr_accept", 32'(hready), 32'd1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    hwdata = wd;
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                    input logic [3:0] ws);
    issue(HTRANS_NONSEQ, a, 1'b1, sz, d, mk(1'b0, HRESP_OKAY, ws, 32'd0));
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                    input logic [3:0] ws);
    issue(HTRANS_NONSEQ, a, 1'b0, sz, 32'd0, mk(1'b1, HRESP_OKAY, ws, d));
  endtask

  task automatic idle_wait();
    int n;
    htrans = HTRANS_IDLE;
    hburst = 3'd0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input int k, input string tag);
    check({tag, "_hreadyout"}, 32'(rdy_v[k]), 32'd1);
    check({tag, "_hresp"}, 32'(resp_v[k]), 32'd0);
    check({tag, "_hrdata"}, rdata_v[k], 32'd0);
    check({tag, "_state"}, 32'(dbg_v[k]), 32'(S_READY));
  endtask

  initial begin
    int n;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_reset_outputs(k, "reset");
    @(posedge clk);
    #1;
    hreset = 1'b0;

    // word write then back-to-back read, and a byte read returns the full word
    wr(32'h8, HSIZE_WORD, 32'hDEADBEEF, 4'd0);
    rd(32'h8, HSIZE_WORD, 32'hDEADBEEF, 4'd0);
    rd(32'h9, HSIZE_BYTE, 32'hDEADBEEF, 4'd0);

    // byte and halfword lanes
    wr(32'h0, HSIZE_WORD, 32'h0000_0000, 4'd0);
    wr(32'h1, HSIZE_BYTE, 32'h0000_AA00, 4'd0);
    wr(32'h2, HSIZE_HALF, 32'h1234_0000, 4'd0);
    rd(32'h0, HSIZE_WORD, 32'h1234_AA00, 4'd0);

    // errors: out of range (index would alias word 0), misaligned, bad size
    issue(HTRANS_NONSEQ, 32'h400, 1'b1, HSIZE_WORD, 32'hFFFF_FFFF, E_ERR);
    rd(32'h0, HSIZE_WORD, 32'h1234_AA00, 4'd0);
    issue(HTRANS_NONSEQ, 32'h2, 1'b0, HSIZE_WORD, 32'd0, E_ERR);
    issue(HTRANS_NONSEQ, 32'h1, 1'b1, HSIZE_HALF, 32'hFFFF_FFFF, E_ERR);
    rd(32'h0, HSIZE_WORD, 32'h1234_AA00, 4'd0);
    issue(HTRANS_NONSEQ, 32'h4, 1'b0, 3'd3, 32'd0, E_ERR);

    // INCR write burst with a BUSY after beat 2
    hburst = 3'd1;
    issue(HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, 32'h1111_1111, mk(1'b0, HRESP_OKAY, 4'd0, 32'd0));
    issue(HTRANS_SEQ,    32'h14, 1'b1, HSIZE_WORD, 32'h2222_2222, mk(1'b0, HRESP_OKAY, 4'd0, 32'd0));
    issue(HTRANS_BUSY,   32'h18, 1'b1, HSIZE_WORD, 32'h0000_0000, mk(1'b1, HRESP_OKAY, 4'd0, 32'd0));
    issue(HTRANS_SEQ,    32'h18, 1'b1, HSIZE_WORD, 32'h3333_3333, mk(1'b0, HRESP_OKAY, 4'd0, 32'd0));
    issue(HTRANS_SEQ,    32'h1C, 1'b1, HSIZE_WORD, 32'h4444_4444, mk(1'b0, HRESP_OKAY, 4'd0, 32'd0));
    hburst = 3'd0;
    rd(32'h10, HSIZE_WORD, 32'h1111_1111, 4'd0);
    rd(32'h14, HSIZE_WORD, 32'h2222_2222, 4'd0);
    rd(32'h18, HSIZE_WORD, 32'h3333_3333, 4'd0);
    rd(32'h1C, HSIZE_WORD, 32'h4444_4444, 4'd0);

    // two wait states; errors ignore the wait-state setting
    wr(32'h1000_0004, HSIZE_WORD, 32'hCAFE_F00D, 4'd2);
    rd(32'h1000_0004, HSIZE_WORD, 32'hCAFE_F00D, 4'd2);
    issue(HTRANS_NONSEQ, 32'h1000_0400, 1'b0, HSIZE_WORD, 32'd0, E_ERR);
    rd(32'h1000_0004, HSIZE_WORD, 32'hCAFE_F00D, 4'd2);
    rd(32'h0000_0008, HSIZE_WORD, 32'hDEADBEEF, 4'd0);

    // three wait states, target word for the reset test
    wr(32'h2000_0020, HSIZE_WORD, 32'h0BAD_F00D, 4'd3);
    rd(32'h2000_0020, HSIZE_WORD, 32'h0BAD_F00D, 4'd3);
    idle_wait();

    // reset pulsed in the middle of a waited write data phase
    track  = 1'b0;
    htrans = HTRANS_NONSEQ;
    haddr  = 32'h2000_0020;
    hwrite = 1'b1;
    hsize  = HSIZE_WORD;
    n = 0;
    @(negedge clk);
    while (!hready && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    htrans = HTRANS_IDLE;
    hwdata = 32'h5555_5555;
    @(negedge clk);
    check("ws3_write_stalled", 32'(hready), 32'd0);
    hreset = 1'b1;
    @(posedge clk);
    #1;
    hreset = 1'b0;
    track  = 1'b1;
    @(negedge clk);
    check_reset_outputs(2, "midreset");
    @(posedge clk);
    #1;
    rd(32'h2000_0020, HSIZE_WORD, 32'h0BAD_F00D, 4'd3);
    rd(32'h0000_0010, HSIZE_WORD, 32'h1111_1111, 4'd0);
    idle_wait();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
